// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction timer: state encoding, LFSR geometry and BCD limits.
// The LFSR step function lives here so the top stays focused on sequencing.
package reaction_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int          LFSR_W  = 14;
  localparam int          WAIT_W  = 14;
  localparam logic [15:0] BCD_MAX = 16'h9999;

  // Fibonacci taps 14,13,12,2; the new bit enters at the LSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    logic fb;
    fb = cur[13] ^ cur[12] ^ cur[11] ^ cur[1];
    return {cur[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/reaction_timer_bcd_counter4.sv
// Four-digit ripple-carry BCD counter with synchronous clear and saturation at 9999.
// clr has priority over inc; inc at 9999 leaves the value unchanged.
module bcd_counter4
  import reaction_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q,
  output logic        at_max
);

  logic [15:0] q_inc;
  logic        carry;

  assign at_max = (q == BCD_MAX);

  // Each digit rolls 9 -> 0 and passes the carry upward; the first digit below 9 absorbs it.
  always_comb begin
    q_inc = q;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (q[4*i +: 4] == 4'd9) begin
          q_inc[4*i +: 4] = 4'd0;
        end else begin
          q_inc[4*i +: 4] = q[4*i +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 16'h0000;
    end else if (clr) begin
      q <= 16'h0000;
    end else if (inc && !at_max) begin
      q <= q_inc;
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time FSM: random wait, LED on, count ms ticks in BCD until stop.
// Handshake: start/stop/tick are sampled each clk; start only acts in IDLE/DONE, stop only in WAIT/RUN.
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter logic [WAIT_W-1:0] MIN_DELAY = 14'd1000,
  parameter int                RAND_W    = 11,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 14'h2A5F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  output logic        tick_en,
  output logic        led,
  output logic [15:0] bcd,
  output logic        result_valid,
  output logic        false_start,
  output logic        overflow,
  output logic [1:0]  state
);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [LFSR_W-1:0]   lfsr_q;
  logic                tick_q, tick_p;
  logic                rv_d, fs_d, ov_d;
  logic                bcd_clr, bcd_inc, bcd_at_max;

  assign tick_p = tick & ~tick_q;
  assign state  = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
      lfsr_q <= LFSR_SEED;
    end else begin
      tick_q <= tick;
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    rv_d    = result_valid;
    fs_d    = false_start;
    ov_d    = overflow;
    bcd_clr = 1'b0;
    bcd_inc = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WAIT;
          wait_d  = MIN_DELAY + WAIT_W'(lfsr_q[RAND_W-1:0]);
          bcd_clr = 1'b1;
          rv_d    = 1'b0;
          fs_d    = 1'b0;
          ov_d    = 1'b0;
        end
      end
      ST_WAIT: begin
        if (stop) begin
          state_d = ST_DONE;
          fs_d    = 1'b1;
        end else if (tick_p) begin
          if (wait_q == WAIT_W'(1)) state_d = ST_RUN;
          else                      wait_d  = wait_q - WAIT_W'(1);
        end
      end
      ST_RUN: begin
        // A tick arriving together with stop is deliberately not counted.
        if (stop) begin
          state_d = ST_DONE;
          rv_d    = 1'b1;
        end else if (tick_p) begin
          if (bcd_at_max) begin
            state_d = ST_DONE;
            ov_d    = 1'b1;
          end else begin
            bcd_inc = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // led and tick_en are registered from the next state so they align with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      tick_en      <= 1'b0;
      led          <= 1'b0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      tick_en      <= (state_d == ST_WAIT) || (state_d == ST_RUN);
      led          <= (state_d == ST_RUN);
      result_valid <= rv_d;
      false_start  <= fs_d;
      overflow     <= ov_d;
    end
  end

  bcd_counter4 u_bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (bcd_clr),
    .inc    (bcd_inc),
    .q      (bcd),
    .at_max (bcd_at_max)
  );

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer: normal, false start, saturation, collision, held tick, reset.
// Trial outcomes go through an expected queue drained by a monitor on the flag rising edge.
module tb_reaction_timer;

  localparam int W = 21;  // {bcd, result_valid, false_start, overflow, tick_en, led}

  logic        clk, rst_n, tick, start, stop;
  logic        tick_en, led, result_valid, false_start, overflow;
  logic [15:0] bcd;
  logic [1:0]  state;

  logic [W-1:0] exp_q[$];
  int           total = 0;
  int           bad   = 0;
  logic [13:0]  m_lfsr;
  int           r;
  logic         led_seen;

  reaction_timer #(
    .MIN_DELAY (14'd5),
    .RAND_W    (2),
    .LFSR_SEED (14'h0001)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .start        (start),
    .stop         (stop),
    .tick_en      (tick_en),
    .led          (led),
    .bcd          (bcd),
    .result_valid (result_valid),
    .false_start  (false_start),
    .overflow     (overflow),
    .state        (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR, taps 14,13,12,2, shifting every clk from the seed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 14'h0001;
    else        m_lfsr <= {m_lfsr[12:0], m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[11] ^ m_lfsr[1]};
  end

  always @(negedge clk) if (led) led_seen = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a trial result is presented when any flag rises.
  logic [2:0] prev_flags = 3'b000;
  always @(negedge clk) begin
    logic [2:0]   cur;
    logic [W-1:0] got, exp;
    cur = {result_valid, false_start, overflow};
    if (!rst_n) begin
      prev_flags = 3'b000;
    end else begin
      if (cur != 3'b000 && prev_flags == 3'b000) begin
        got = {bcd, cur, tick_en, led};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected: got %h expected none", got);
        end else begin
          exp = exp_q.pop_front();
          check("done_result", 32'(got), 32'(exp));
        end
      end
      prev_flags = cur;
    end
  end

  // Driver tasks (all return on a negedge)
  task automatic pulse_start();
    start = 1'b1;
    r = int'(m_lfsr[1:0]);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic send_tick(input int hold);
    tick = 1'b1;
    repeat (hold) @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  // Start a trial and deliver ticks up to and including the one that ends WAIT.
  task automatic reach_run(input string tag);
    pulse_start();
    repeat (4 + r) send_tick(1);
    check({tag, "_wait_state"}, 32'(state), 32'd1);
    check({tag, "_led_before"}, 32'(led), 32'd0);
    tick = 1'b1;
    @(negedge clk);
    check({tag, "_led_rise"}, 32'({led, state}), 32'b110);
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d pending expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic normal_trial(input string tag);
    reach_run(tag);
    repeat (37) send_tick(1);
    exp_q.push_back({16'h0037, 3'b100, 1'b0, 1'b0});
    pulse_stop();
    drain(tag);
    check({tag, "_state_done"}, 32'(state), 32'd3);
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {tick_en, led, result_valid, false_start, overflow, bcd, state},
          32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. Normal trial
    normal_trial("normal");
    check("normal_tick_en", 32'(tick_en), 32'd0);

    // 2. False start
    led_seen = 1'b0;
    pulse_start();
    check("restart_clears", 32'({bcd, result_valid, false_start, overflow, state}), 32'd1);
    repeat (2) send_tick(1);
    exp_q.push_back({16'h0000, 3'b010, 1'b0, 1'b0});
    pulse_stop();
    drain("false_start");
    check("false_led_never", 32'(led_seen), 32'd0);

    // 3. Saturation
    reach_run("sat");
    for (int i = 1; i <= 10000; i++) begin
      if (i == 10000) exp_q.push_back({16'h9999, 3'b001, 1'b0, 1'b0});
      send_tick(1);
      if (i == 99)   check("sat_0099", 32'(bcd), 32'h0099);
      if (i == 100)  check("sat_0100", 32'(bcd), 32'h0100);
      if (i == 9999) check("sat_9999_run", 32'({bcd, state}), {14'd0, 16'h9999, 2'd2});
    end
    drain("sat");
    check("sat_done", 32'(state), 32'd3);

    // 4. Stop and tick in the same clk
    reach_run("coll");
    repeat (12) send_tick(1);
    check("coll_0012", 32'(bcd), 32'h0012);
    exp_q.push_back({16'h0012, 3'b100, 1'b0, 1'b0});
    tick = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    stop = 1'b0;
    drain("coll");

    // 5. Held tick counts once, then restart from DONE
    reach_run("held");
    send_tick(6);
    check("held_once", 32'(bcd), 32'h0001);
    exp_q.push_back({16'h0001, 3'b100, 1'b0, 1'b0});
    pulse_stop();
    drain("held");
    pulse_start();
    check("restart_wait", 32'({bcd, result_valid, false_start, overflow, tick_en, state}),
          32'b1_01);

    // 6. Reset mid-RUN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    reach_run("rst");
    repeat (250) send_tick(1);
    check("rst_0250", 32'(bcd), 32'h0250);
    rst_n = 1'b0;
    #1;
    check("rst_async", 32'({led, tick_en, bcd, state}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    normal_trial("post_rst");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
